// File: rtl/sad_modesel_luma4x4.sv
`default_nettype none
// ============================================================================
// sad_modesel_luma4x4
// Latches eight 4x4 residual blocks, finds the minimum-SAD intra mode by
// scanning one row per cycle, and hands the winner downstream on valid/ready.
// Revision: 1.0
// ============================================================================
module sad_modesel_luma4x4 (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic signed [7:0]  vres    [0:15],
    input  logic signed [7:0]  hres    [0:15],
    input  logic signed [7:0]  vlres   [0:15],
    input  logic signed [7:0]  vrres   [0:15],
    input  logic signed [7:0]  hures   [0:15],
    input  logic signed [7:0]  hdres   [0:15],
    input  logic signed [7:0]  ddlres  [0:15],
    input  logic signed [7:0]  ddrres  [0:15],
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         best_mode,
    output logic [11:0]        best_sad,
    output logic signed [7:0]  best_res [0:15]
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic signed [7:0]   r_bank [0:7][0:15];
    logic signed [7:0]   w_in   [0:7][0:15];
    logic [2:0]          r_m;
    logic [1:0]          r_r;
    logic [11:0]         r_acc;
    logic [11:0]         r_best_sad;
    logic [2:0]          r_best_mode;
    logic [7:0]          w_abs  [0:3];
    logic [9:0]          w_rowsad;
    logic [11:0]         w_total;
    logic                w_accept;
    logic                w_last_row;

    // Magnitude as unsigned 8 bits: -128 maps to 128 without overflow.
    function automatic logic [7:0] abs8(input logic signed [7:0] x);
        abs8 = x[7] ? ((~x) + 8'd1) : x;
    endfunction

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_in[0][i] = vres[i];
            w_in[1][i] = hres[i];
            w_in[2][i] = vlres[i];
            w_in[3][i] = vrres[i];
            w_in[4][i] = hures[i];
            w_in[5][i] = hdres[i];
            w_in[6][i] = ddlres[i];
            w_in[7][i] = ddrres[i];
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            w_abs[c] = abs8(r_bank[r_m][{r_r, c[1:0]}]);
        end
        w_rowsad = {2'b00, w_abs[0]} + {2'b00, w_abs[1]}
                 + {2'b00, w_abs[2]} + {2'b00, w_abs[3]};
        w_total  = r_acc + {2'b00, w_rowsad};
    end

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_last_row = (r_r == 2'd3);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SCAN;
            S_SCAN:  if (r_m == 3'd7 && w_last_row) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int m = 0; m < 8; m++) begin
                for (int i = 0; i < 16; i++) begin
                    r_bank[m][i] <= 8'sd0;
                end
            end
            r_m         <= 3'd0;
            r_r         <= 2'd0;
            r_acc       <= 12'd0;
            r_best_sad  <= 12'd0;
            r_best_mode <= 3'd0;
        end else if (w_accept) begin
            r_bank <= w_in;
            r_m    <= 3'd0;
            r_r    <= 2'd0;
            r_acc  <= 12'd0;
        end else if (r_state == S_SCAN) begin
            if (!w_last_row) begin
                r_acc <= w_total;
                r_r   <= r_r + 2'd1;
            end else begin
                // Strict compare keeps the lowest mode index on ties.
                if (r_m == 3'd0 || w_total < r_best_sad) begin
                    r_best_sad  <= w_total;
                    r_best_mode <= r_m;
                end
                r_acc <= 12'd0;
                r_r   <= 2'd0;
                r_m   <= r_m + 3'd1;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign best_mode = r_best_mode;
    assign best_sad  = r_best_sad;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            best_res[i] = r_bank[r_best_mode][i];
        end
    end

endmodule
`default_nettype wire
